add_share_arbiter: RTL
======================

Name: add_share_arbiter

Overview:
- Shares one sample-then-add unit among N_REQ requesters.
- Each requester presents an operand pair with a level request.
- A round-robin arbiter grants one requester, sequences the adder through its sample/done handshake, and returns the sum tagged with the requester index.
- Sits between client blocks and the single adder instance. The adder has no reset, so a timeout guards a missing done.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 4, operand width; sum width is W+1.
- TIMEOUT, 15, maximum WAIT cycles before an error response (1..255).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  level request per requester; held until its gnt bit pulses
- req_a  input  N_REQ*W  packed operand A; slice i belongs to requester i
- req_b  input  N_REQ*W  packed operand B
- gnt  output  N_REQ  one-hot, one-cycle grant pulse; operands already captured
- rsp_valid  output  1  one-cycle response strobe
- rsp_id  output  $clog2(N_REQ)  index of the responding requester
- rsp_sum  output  W+1  result; 0 when rsp_err=1
- rsp_err  output  1  adder did not signal done within TIMEOUT
- busy  output  1  high in every state except IDLE
- add_sample  output  1  sample strobe to the adder
- add_a  output  W  operand A to the adder
- add_b  output  W  operand B to the adder
- add_s  input  W+1  adder sum
- add_done  input  1  adder done; cleared by the adder at the sample edge, set one edge later

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - gnt, rsp_valid, rsp_err, add_sample, busy = 0.
  - rsp_id, rsp_sum, add_a, add_b = 0.
  - Round-robin pointer ptr=0; timer=0.
- All outputs are registered. add_a/add_b come from internal operand registers, held stable from ISSUE until the next grant.
- IDLE:
  - If req != 0, pick the first set bit searching ptr, ptr+1, ... modulo N_REQ.
  - Latch id, a, b; set ptr=(id+1) mod N_REQ; go to ISSUE.
  - add_done is ignored in IDLE.
- ISSUE (1 cycle):
  - add_sample=1 and gnt[id]=1 in this cycle.
  - timer=0; go to WAIT.
- WAIT:
  - If add_done=1: capture add_s into rsp_sum, rsp_err=0, go to RESP.
  - Else: timer++.
  - If timer reaches TIMEOUT with no done: rsp_sum=0, rsp_err=1, go to RESP.
  - The first WAIT cycle always sees done=0, because the adder clears done at the sample edge.
- RESP (1 cycle):
  - rsp_valid=1 with rsp_id=id; go to IDLE.
  - rsp_sum/rsp_err/rsp_id hold until the next RESP.
- Latency:
  - Req seen in IDLE to rsp_valid: 4 cycles (IDLE, ISSUE, WAIT×2, then RESP).
  - Back-to-back period is 5 cycles per transaction.
- Arithmetic: sum is unsigned W+1 bits. Overflow is impossible; the carry appears in bit W.
- Requester rules:
  - A requester holds req and its operands until it sees gnt.
  - It may drop or re-raise req at any time after gnt.
  - A req dropped before grant is simply not granted; there is no error.
- Simultaneous requests: exactly one gnt bit per transaction. No requester waits more than N_REQ-1 transactions.
- Reset mid-operation:
  - Abort immediately; no rsp_valid is issued for the aborted transaction.
  - A late add_done from the unreset adder is ignored in IDLE.
- gnt and add_sample are never high outside ISSUE. rsp_valid is never high outside RESP.

Decomposition:
- Package add_share_pkg:
  - State enum (IDLE, ISSUE, WAIT, RESP), 2-bit encoding.
  - Id-width and timer-width helper constants.
- Sub-module rr_pick: combinational, parameterised N_REQ. Takes req and ptr; outputs found and idx (rotate, priority-encode, un-rotate).

Test Plan:
- Single request: req=0001, a0=3, b0=5 -> gnt=0001 for 1 cycle, add_sample coincident, rsp_valid 4 cycles after request with rsp_id=0, rsp_sum=8, rsp_err=0.
- Overflow: a=15, b=15 -> rsp_sum=5'b11110 (30).
- Fairness: req=1111 held continuously after each grant -> rsp_id sequence 0,1,2,3,0; one transaction per 5 cycles.
- Pointer skip: ptr=2 after granting requester 1, req=0011 -> next grant is requester 0, then requester 1.
- Timeout: adder model never raises done -> rsp_valid after TIMEOUT WAIT cycles with rsp_err=1, rsp_sum=0; the next request completes normally.
- Reset in WAIT: assert rst_n=0 one cycle after ISSUE -> all outputs 0 at once, no rsp_valid; after release, a new request gives the correct sum and ptr restarts at 0.

Source files
------------

// File: rtl/add_share_arbiter_pkg.sv
// rtl/add_share_arbiter_pkg.sv - shared types and width helpers for the adder-sharing arbiter
// Contents: state_t (IDLE/ISSUE/WAIT/RESP, 2-bit), TIMER_W, id_w() for requester index width.
package add_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // TIMEOUT is bounded to 255, so eight bits always hold the wait count.
    localparam int TIMER_W = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_share_arbiter_if.sv
// rtl/add_share_arbiter_if.sv - requester, response and adder-side signal bundle
// Ports: req/req_a/req_b in from clients, gnt and rsp_* back to them,
//        add_sample/add_a/add_b out to the adder, add_s/add_done back from it, busy status.
// Modports: slave = the arbiter, master = the clients plus adder model around it.
interface add_share_arbiter_if
    import add_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 4
);
    localparam int IDW = id_w(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ-1:0]   gnt;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [W:0]         rsp_sum;
    logic               rsp_err;
    logic               busy;
    logic               add_sample;
    logic [W-1:0]       add_a;
    logic [W-1:0]       add_b;
    logic [W:0]         add_s;
    logic               add_done;

    modport slave (
        input  req, req_a, req_b, add_s, add_done,
        output gnt, rsp_valid, rsp_id, rsp_sum, rsp_err, busy, add_sample, add_a, add_b
    );

    modport master (
        output req, req_a, req_b, add_s, add_done,
        input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_err, busy, add_sample, add_a, add_b
    );

endinterface

// File: rtl/add_share_arbiter_rr_pick.sv
// rtl/add_share_arbiter_rr_pick.sv - combinational round-robin requester picker
// Ports: req (request vector), ptr (highest-priority index) -> found, idx (chosen requester).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             found,
    output logic [IDW-1:0]   idx
);

    logic [N_REQ-1:0] rot;
    logic [IDW-1:0]   enc;

    // Rotate so that requester ptr lands in bit 0; lowest set bit then wins.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[IDW'((i + int'(ptr)) % N_REQ)];
        end
    end

    always_comb begin
        found = 1'b0;
        enc   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                enc   = IDW'(i);
            end
        end
    end

    assign idx = IDW'((int'(enc) + int'(ptr)) % N_REQ);

endmodule

// File: rtl/add_share_arbiter.sv
// rtl/add_share_arbiter.sv - round-robin sharing of one sample-then-add unit among N_REQ clients
// Ports: clk, rst_n (async active-low), bus (add_share_arbiter_if.slave): client req/operands in,
//        one-hot gnt and tagged rsp_* out, adder sample/operands out, adder sum/done in, busy.
module add_share_arbiter
    import add_share_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    add_share_arbiter_if.slave  bus
);

    localparam int IDW = id_w(N_REQ);

    state_t               state_q, state_n;
    logic [IDW-1:0]       id_q, id_n;
    logic [IDW-1:0]       ptr_q, ptr_n;
    logic [W-1:0]         a_q, a_n, b_q, b_n;
    logic [TIMER_W-1:0]   timer_q, timer_n;
    logic [N_REQ-1:0]     gnt_q, gnt_n;
    logic                 sample_q, sample_n;
    logic                 rsp_valid_q, rsp_valid_n;
    logic [IDW-1:0]       rsp_id_q, rsp_id_n;
    logic [W:0]           rsp_sum_q, rsp_sum_n;
    logic                 rsp_err_q, rsp_err_n;
    logic                 busy_q, busy_n;

    logic                 pick_found;
    logic [IDW-1:0]       pick_idx;

    rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= '0;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            timer_q     <= '0;
            gnt_q       <= '0;
            sample_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            id_q        <= id_n;
            ptr_q       <= ptr_n;
            a_q         <= a_n;
            b_q         <= b_n;
            timer_q     <= timer_n;
            gnt_q       <= gnt_n;
            sample_q    <= sample_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_id_q    <= rsp_id_n;
            rsp_sum_q   <= rsp_sum_n;
            rsp_err_q   <= rsp_err_n;
            busy_q      <= busy_n;
        end
    end

    // Next values are computed for the state being entered, so every strobe
    // is a register that is high exactly during its own state.
    always_comb begin
        state_n     = state_q;
        id_n        = id_q;
        ptr_n       = ptr_q;
        a_n         = a_q;
        b_n         = b_q;
        timer_n     = timer_q;
        gnt_n       = '0;
        sample_n    = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_id_n    = rsp_id_q;
        rsp_sum_n   = rsp_sum_q;
        rsp_err_n   = rsp_err_q;

        case (state_q)
            IDLE: begin
                // add_done is deliberately not looked at here: a stale done
                // from an aborted transaction must not produce a response.
                if (pick_found) begin
                    state_n           = ISSUE;
                    id_n              = pick_idx;
                    a_n               = bus.req_a[pick_idx*W +: W];
                    b_n               = bus.req_b[pick_idx*W +: W];
                    ptr_n             = IDW'((int'(pick_idx) + 1) % N_REQ);
                    gnt_n[pick_idx]   = 1'b1;
                    sample_n          = 1'b1;
                end
            end
            ISSUE: begin
                state_n = WAIT;
                timer_n = '0;
            end
            WAIT: begin
                if (bus.add_done) begin
                    state_n     = RESP;
                    rsp_sum_n   = bus.add_s;
                    rsp_err_n   = 1'b0;
                    rsp_id_n    = id_q;
                    rsp_valid_n = 1'b1;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th WAIT cycle without done.
                    state_n     = RESP;
                    rsp_sum_n   = '0;
                    rsp_err_n   = 1'b1;
                    rsp_id_n    = id_q;
                    rsp_valid_n = 1'b1;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.gnt        = gnt_q;
    assign bus.add_sample = sample_q;
    assign bus.add_a      = a_q;
    assign bus.add_b      = b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = busy_q;

endmodule
